// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: pointer-width helper and parameter legality check shared by the FIFO modules.
package sync_fifo_pkg;
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic bit thresh_ok(input int depth, input int af, input int ae);
    return depth >= 4 && (depth & (depth - 1)) == 0 &&
           af >= 1 && af <= depth && ae >= 0 && ae <= depth - 1;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: WIDTH x DEPTH storage, synchronous write; read port registered, or combinational
// when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR = $clog2(DEPTH)
) (
  input  logic             clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic             rst,
  input  logic             re,
`endif
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDR-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
`endif
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, almost flags and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_param import sync_fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int ADDR = $clog2(DEPTH),
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wen,
  input  logic [WIDTH-1:0] wr,
  input  logic             ren,
  output logic [WIDTH-1:0] rd,
  output logic             valid,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  if (!thresh_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DEPTH or threshold parameters");
  end
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);
  logic [PW-1:0] wptr, rptr;
  logic          we, re;
  assign empty        = wptr == rptr;
  assign full         = wptr[ADDR] != rptr[ADDR] && wptr[ADDR-1:0] == rptr[ADDR-1:0];
  assign count        = wptr - rptr;
  assign almost_full  = count >= AF_T;
  assign almost_empty = count <= AE_T;
  // a flush swallows same-cycle requests so nothing lands in or leaves the array
  assign we = wen && !full && !clr;
  assign re = ren && !empty && !clr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr + PW'(we);
      rptr      <= rptr + PW'(re);
      overflow  <= wen && full;
      underflow <= ren && empty;
    end
`ifdef SYNC_FIFO_FWFT_EN
  assign valid = !empty;
  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(we), .waddr(wptr[ADDR-1:0]), .wdata(wr),
    .raddr(rptr[ADDR-1:0]), .rdata(rd)
  );
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) valid <= 1'b0;
    else valid <= re;
  sync_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .rst(rst), .re(re), .we(we), .waddr(wptr[ADDR-1:0]), .wdata(wr),
    .raddr(rptr[ADDR-1:0]), .rdata(rd)
  );
`endif
endmodule
